rom_port_arbiter: RTL and testbench
===================================

# rom_port_arbiter

Two-port arbiter that shares the single combinational program ROM between the instruction-fetch stage and the FP/integer load path (FLW/LW to read-only data). Each cycle it accepts at most one word read, drives the ROM address, and returns the registered word to the winning port one cycle later. Arbitration is load-priority with a starvation limiter that guarantees fetch forward progress.

## Interface
- ADDRLEN, 16: byte-address width of the ROM, matching `ADDRLEN.
- XLEN, 32: data word width.
- LD_BURST, 3: maximum consecutive contended cycles the load port may win before fetch is forced.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request, level, held until accepted.
- if_addr  in  ADDRLEN  fetch byte address.
- if_gnt  out  1  combinational accept for fetch this cycle.
- if_rvalid  out  1  registered one-cycle pulse; if_rdata valid.
- if_rdata  out  XLEN  fetched word.
- ld_req  in  1  load request, level, held until accepted.
- ld_addr  in  ADDRLEN  load byte address.
- ld_gnt  out  1  combinational accept for load this cycle.
- ld_rvalid  out  1  registered one-cycle pulse; ld_rdata/ld_misalign valid.
- ld_rdata  out  XLEN  loaded word.
- ld_misalign  out  1  ld_addr[1:0] != 0 on the accepted load.
- rom_addr  out  ADDRLEN  address to ROM, always word-aligned.
- rom_data  in  XLEN  combinational ROM output for rom_addr.

## Operation
- Grant rule, per cycle:
  - Only one request: grant it.
  - Both requests: grant load unless `run_cnt == LD_BURST`; in that case grant fetch.
  - Neither request: no grant; rom_addr = {if_addr[ADDRLEN-1:2],2'b00}.
- rom_addr = winner's address with bits [1:0] forced to 0.
- Starvation counter `run_cnt`, ceil(log2(LD_BURST+1)) bits:
  - Increments on a contended load grant.
  - Clears on any fetch grant and on any cycle without contention.
  - Saturates at LD_BURST and never wraps.
- Response registers, updated on rising clk:
  - `if_rvalid <= if_gnt`; `ld_rvalid <= ld_gnt`.
  - On the granted port only, rdata <= rom_data.
  - ld_misalign <= ld_addr[1] | ld_addr[0], loaded only on ld_gnt.
  - rdata of the non-granted port holds its last value.
- Misaligned load is still serviced from the aligned word; ld_misalign is advisory so the core can raise its trap. Fetch alignment is not checked (the PC is always aligned).
- No internal FSM beyond `run_cnt`. Arbitration states:
  - LDPRI: run_cnt < LD_BURST.
  - FORCE_IF: run_cnt == LD_BURST. Leaves on the next fetch grant or an uncontended cycle.
- Requesters must keep req/addr stable until gnt. The arbiter does not check this.

## Timing
- Accept-to-data latency: exactly 1 cycle. Data is presented in cycle N+1 for a grant in cycle N.
- Throughput: 1 word/cycle total, back-to-back grants allowed on either port.
- if_gnt and ld_gnt are never both 1. A gnt is never asserted without the matching req.
- Reset values (asynchronous, immediate on rst_n low): if_rvalid=0, ld_rvalid=0, if_rdata=0, ld_rdata=0, ld_misalign=0, run_cnt=0.
- Reset mid-transfer: an in-flight response is dropped (rvalid is forced to 0). Requesters reissue after reset.
- First cycle after reset release: load has priority (run_cnt=0).
- Simultaneous req rise with a FORCE_IF condition: fetch wins, and run_cnt clears at the same edge.

## Test plan
- Reset and basic fetch: the bench ROM model holds 0x000002B3 @0x000 and 0x00B00313 @0x004.
  - Stimulus: if_req with 0x000, then 0x004, on consecutive cycles.
  - Response: if_gnt=1 both cycles; if_rvalid pulses with if_rdata 0x000002B3, then 0x00B00313, each one cycle after its grant.
- Load priority:
  - Stimulus: if_req@0x100 and ld_req@0x004 in the same cycle.
  - Response: ld_gnt=1, if_gnt=0, rom_addr=0x004. Next cycle ld_rvalid=1 with ld_rdata=0x00B00313, and if_gnt=1 if ld_req has dropped.
- Starvation limit with LD_BURST=3:
  - Stimulus: continuous if_req and ld_req for 8 cycles.
  - Response: grant pattern L,L,L,F,L,L,L,F. run_cnt never exceeds 3.
- Misaligned load:
  - Stimulus: ld_req@0x006.
  - Response: rom_addr=0x004, ld_rdata=0x00B00313, ld_misalign=1 with ld_rvalid. A following ld_req@0x000 returns ld_misalign=0.
- Async reset mid-flight:
  - Stimulus: assert rst_n=0 half a cycle after a fetch grant.
  - Response: if_rvalid=0 and if_rdata=0 immediately. After release, a contended request grants load first.
- Idle:
  - Stimulus: no requests for 4 cycles, then a single ld_req.
  - Response: no gnt/rvalid during idle, run_cnt=0, then a normal 1-cycle-latency load response.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one combinational program ROM between instruction
// fetch and the read-only load path. Loads win contended cycles until they
// have won LD_BURST contended cycles in a row. After that, fetch is forced
// through once so it always makes forward progress. Read data comes back
// registered, one cycle after the grant.

module rom_port_arbiter #(
    parameter int ADDRLEN  = 16,
    parameter int XLEN     = 32,
    parameter int LD_BURST = 3
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               if_req,
    input  logic [ADDRLEN-1:0] if_addr,
    output logic               if_gnt,
    output logic               if_rvalid,
    output logic [XLEN-1:0]    if_rdata,

    input  logic               ld_req,
    input  logic [ADDRLEN-1:0] ld_addr,
    output logic               ld_gnt,
    output logic               ld_rvalid,
    output logic [XLEN-1:0]    ld_rdata,
    output logic               ld_misalign,

    output logic [ADDRLEN-1:0] rom_addr,
    input  logic [XLEN-1:0]    rom_data
);

    localparam int CNT_W = (LD_BURST < 1) ? 1 : $clog2(LD_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(LD_BURST);

    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic             if_rvalid_q, if_rvalid_d;
    logic             ld_rvalid_q, ld_rvalid_d;
    logic [XLEN-1:0]  if_rdata_q, if_rdata_d;
    logic [XLEN-1:0]  ld_rdata_q, ld_rdata_d;
    logic             ld_misalign_q, ld_misalign_d;

    logic             contended;
    logic             force_if;
    logic             if_gnt_c;
    logic             ld_gnt_c;
    logic [ADDRLEN-1:0] rom_addr_c;

    // The PC is always aligned, so the low fetch address bits carry no information.
    logic unused_if_lsb;
    assign unused_if_lsb = ^if_addr[1:0];

    // Grant decision and ROM address mux. Load wins ties unless the burst limit has been reached.
    always_comb begin
        contended  = if_req & ld_req;
        force_if   = (run_cnt_q == BURST_MAX);
        ld_gnt_c   = ld_req & ~(if_req & force_if);
        if_gnt_c   = if_req & ~ld_gnt_c;
        rom_addr_c = {if_addr[ADDRLEN-1:2], 2'b00};
        if (ld_gnt_c) begin
            rom_addr_c = {ld_addr[ADDRLEN-1:2], 2'b00};
        end
    end

    // Starvation counter. It counts contended load wins, saturates at the limit,
    // and clears on a fetch grant or on any uncontended cycle.
    always_comb begin
        run_cnt_d = '0;
        if (contended && ld_gnt_c) begin
            if (run_cnt_q == BURST_MAX) begin
                run_cnt_d = run_cnt_q;
            end else begin
                run_cnt_d = run_cnt_q + 1'b1;
            end
        end
    end

    // Response capture. Only the granted port samples the ROM, and the other port holds its data.
    always_comb begin
        if_rvalid_d   = if_gnt_c;
        ld_rvalid_d   = ld_gnt_c;
        if_rdata_d    = if_rdata_q;
        ld_rdata_d    = ld_rdata_q;
        ld_misalign_d = ld_misalign_q;
        if (if_gnt_c) begin
            if_rdata_d = rom_data;
        end
        if (ld_gnt_c) begin
            ld_rdata_d    = rom_data;
            ld_misalign_d = ld_addr[1] | ld_addr[0];
        end
    end

    // State registers. Asynchronous reset drops any in-flight response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt_q     <= '0;
            if_rvalid_q   <= 1'b0;
            ld_rvalid_q   <= 1'b0;
            if_rdata_q    <= '0;
            ld_rdata_q    <= '0;
            ld_misalign_q <= 1'b0;
        end else begin
            run_cnt_q     <= run_cnt_d;
            if_rvalid_q   <= if_rvalid_d;
            ld_rvalid_q   <= ld_rvalid_d;
            if_rdata_q    <= if_rdata_d;
            ld_rdata_q    <= ld_rdata_d;
            ld_misalign_q <= ld_misalign_d;
        end
    end

    assign if_gnt      = if_gnt_c;
    assign ld_gnt      = ld_gnt_c;
    assign rom_addr    = rom_addr_c;
    assign if_rvalid   = if_rvalid_q;
    assign if_rdata    = if_rdata_q;
    assign ld_rvalid   = ld_rvalid_q;
    assign ld_rdata    = ld_rdata_q;
    assign ld_misalign = ld_misalign_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: directed scenarios followed by randomized traffic.
// A behavioural reference model tracks the grants and responses.

module tb_rom_port_arbiter;

    localparam int ADDRLEN  = 16;
    localparam int XLEN     = 32;
    localparam int LD_BURST = 3;

    logic               clk;
    logic               rst_n;
    logic               if_req, ld_req;
    logic [ADDRLEN-1:0] if_addr, ld_addr;
    logic               if_gnt, ld_gnt;
    logic               if_rvalid, ld_rvalid, ld_misalign;
    logic [XLEN-1:0]    if_rdata, ld_rdata;
    logic [ADDRLEN-1:0] rom_addr;
    logic [XLEN-1:0]    rom_data;

    int checks;
    int errors;

    // Reference model state.
    int              m_load_streak;
    logic            m_if_gnt, m_ld_gnt;
    logic            m_if_rvalid, m_ld_rvalid, m_ld_misalign;
    logic [XLEN-1:0] m_if_rdata, m_ld_rdata;

    rom_port_arbiter #(
        .ADDRLEN  (ADDRLEN),
        .XLEN     (XLEN),
        .LD_BURST (LD_BURST)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_gnt      (if_gnt),
        .if_rvalid   (if_rvalid),
        .if_rdata    (if_rdata),
        .ld_req      (ld_req),
        .ld_addr     (ld_addr),
        .ld_gnt      (ld_gnt),
        .ld_rvalid   (ld_rvalid),
        .ld_rdata    (ld_rdata),
        .ld_misalign (ld_misalign),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data)
    );

    // ROM contents: two known instructions, then an address-derived pattern everywhere else.
    function automatic logic [XLEN-1:0] rom_word(input logic [ADDRLEN-1:0] a);
        if (a == 16'h0000) return 32'h0000_02B3;
        if (a == 16'h0004) return 32'h00B0_0313;
        return {a ^ 16'hA5C3, a};
    endfunction

    assign rom_data = rom_word(rom_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_load_streak = 0;
        m_if_gnt      = 1'b0;
        m_ld_gnt      = 1'b0;
        m_if_rvalid   = 1'b0;
        m_ld_rvalid   = 1'b0;
        m_ld_misalign = 1'b0;
        m_if_rdata    = '0;
        m_ld_rdata    = '0;
    endtask

    // Drives one cycle of requests. It is entered just after a rising edge. It checks
    // the combinational grant mid-cycle and the registered response after the next edge.
    task automatic applyStimulus(input logic ifr, input logic [ADDRLEN-1:0] ifa,
                                 input logic ldr, input logic [ADDRLEN-1:0] lda);
        logic [ADDRLEN-1:0] exp_addr;
        if_req  = ifr;
        if_addr = ifa;
        ld_req  = ldr;
        ld_addr = lda;
        #3;
        // Loads win ties until they have won LD_BURST contended cycles in a row.
        m_ld_gnt = ldr && (!ifr || m_load_streak < LD_BURST);
        m_if_gnt = ifr && !m_ld_gnt;
        exp_addr = m_ld_gnt ? (lda & 16'hFFFC) : (ifa & 16'hFFFC);
        checkOutput("if_gnt",   32'(if_gnt),   32'(m_if_gnt));
        checkOutput("ld_gnt",   32'(ld_gnt),   32'(m_ld_gnt));
        checkOutput("rom_addr", 32'(rom_addr), 32'(exp_addr));
        m_load_streak = (ifr && ldr && m_ld_gnt) ? m_load_streak + 1 : 0;
        m_if_rvalid = m_if_gnt;
        m_ld_rvalid = m_ld_gnt;
        if (m_if_gnt) m_if_rdata = rom_word(ifa & 16'hFFFC);
        if (m_ld_gnt) begin
            m_ld_rdata    = rom_word(lda & 16'hFFFC);
            m_ld_misalign = (lda[1:0] != 2'b00);
        end
        @(posedge clk);
        #1;
        checkOutput("if_rvalid",   32'(if_rvalid),   32'(m_if_rvalid));
        checkOutput("if_rdata",    if_rdata,         m_if_rdata);
        checkOutput("ld_rvalid",   32'(ld_rvalid),   32'(m_ld_rvalid));
        checkOutput("ld_rdata",    ld_rdata,         m_ld_rdata);
        checkOutput("ld_misalign", 32'(ld_misalign), 32'(m_ld_misalign));
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_if_rvalid",   32'(if_rvalid),   32'd0);
        checkOutput("rst_if_rdata",    if_rdata,         32'd0);
        checkOutput("rst_ld_rvalid",   32'(ld_rvalid),   32'd0);
        checkOutput("rst_ld_rdata",    ld_rdata,         32'd0);
        checkOutput("rst_ld_misalign", 32'(ld_misalign), 32'd0);
    endtask

    logic               p_if, p_ld;
    logic [ADDRLEN-1:0] p_ifa, p_lda;

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        if_req  = 1'b0;
        ld_req  = 1'b0;
        if_addr = '0;
        ld_addr = '0;
        modelReset();

        // Reset values.
        #12;
        checkResetOutputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] basic fetch");
        applyStimulus(1'b1, 16'h0000, 1'b0, 16'h0000);
        applyStimulus(1'b1, 16'h0004, 1'b0, 16'h0000);

        $display("[TB] load priority");
        applyStimulus(1'b1, 16'h0100, 1'b1, 16'h0004);
        applyStimulus(1'b1, 16'h0100, 1'b0, 16'h0000);

        $display("[TB] starvation limit");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 16'(16'h0200 + 4 * i), 1'b1, 16'(16'h0400 + 4 * i));
        end

        $display("[TB] misaligned load");
        applyStimulus(1'b0, 16'h0000, 1'b1, 16'h0006);
        applyStimulus(1'b0, 16'h0000, 1'b1, 16'h0000);

        $display("[TB] idle then load");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 16'h0010, 1'b0, 16'h0020);
        end
        applyStimulus(1'b0, 16'h0000, 1'b1, 16'h0008);

        $display("[TB] async reset mid-flight");
        applyStimulus(1'b1, 16'h0004, 1'b0, 16'h0000);
        if_req = 1'b0;
        ld_req = 1'b0;
        #4;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkResetOutputs();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 16'h0100, 1'b1, 16'h0004);

        $display("[TB] random traffic");
        p_if  = 1'b0;
        p_ld  = 1'b0;
        p_ifa = '0;
        p_lda = '0;
        for (int i = 0; i < 400; i++) begin
            if (!p_if && ($urandom_range(0, 3) != 0)) begin
                p_if  = 1'b1;
                p_ifa = 16'($urandom) & 16'hFFFC;
            end
            if (!p_ld && ($urandom_range(0, 2) != 0)) begin
                p_ld  = 1'b1;
                p_lda = 16'($urandom);
            end
            applyStimulus(p_if, p_ifa, p_ld, p_lda);
            if (m_if_gnt) p_if = 1'b0;
            if (m_ld_gnt) p_ld = 1'b0;
        end

        if_req = 1'b0;
        ld_req = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
